// File: rtl/a2d_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D converter.
// Optional A2D_RAMP_EN: the returned channel increments on each good frame.
module a2d_resp #(
  parameter int SCLK_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr_en,
  input  logic [2:0]  wr_chnl,
  input  logic [11:0] wr_data,
  output logic        trans_done,
  output logic        frm_err,
  output logic [2:0]  cur_chnl,
  output logic [7:0]  trans_cnt
);

  localparam int N = SCLK_SYNC_STAGES;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [N-1:0] ss_q;
  logic [N-1:0] sclk_q;
  logic [N-1:0] mosi_q;
  logic        ss_d;
  logic        sclk_d;
  logic        ss_s;
  logic        sclk_s;
  logic        mosi_s;
  logic        ss_fall;
  logic        ss_rise;
  logic        sclk_rise;
  logic        sclk_fall;
  logic        good_end;
  logic [15:0] tx_shft;
  logic [15:0] rx_shft;
  logic [4:0]  bit_cnt;
  logic [11:0] regs [8];

  assign ss_s   = ss_q[N-1];
  assign sclk_s = sclk_q[N-1];
  assign mosi_s = mosi_q[N-1];

  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  assign good_end = (state == SHIFT) && ss_rise &&
                    (bit_cnt == 5'd16);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_q   <= '1;
      sclk_q <= '0;
      mosi_q <= '0;
      ss_d   <= 1'b1;
      sclk_d <= 1'b0;
    end else begin
      ss_q   <= {ss_q[N-2:0], SS_n};
      sclk_q <= {sclk_q[N-2:0], SCLK};
      mosi_q <= {mosi_q[N-2:0], MOSI};
      ss_d   <= ss_s;
      sclk_d <= sclk_s;
    end
  end

  // A same-cycle write to the ramped channel overrides the increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
`ifdef A2D_RAMP_EN
      if (good_end)
        regs[cur_chnl] <= regs[cur_chnl] + 12'd1;
`else
      if (good_end && 1'b0)
        regs[cur_chnl] <= regs[cur_chnl];
`endif
      if (wr_en)
        regs[wr_chnl] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_shft    <= '0;
      rx_shft    <= '0;
      bit_cnt    <= '0;
      cur_chnl   <= '0;
      trans_cnt  <= '0;
      trans_done <= 1'b0;
      frm_err    <= 1'b0;
      MISO       <= 1'b0;
    end else begin
      trans_done <= 1'b0;
      frm_err    <= 1'b0;
      MISO       <= (state == SHIFT) ? tx_shft[15] : 1'b0;
      unique case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shft <= {4'b0000, regs[cur_chnl]};
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt == 5'd16) begin
              cur_chnl   <= rx_shft[13:11];
              trans_cnt  <= trans_cnt + 8'd1;
              trans_done <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_shft <= {rx_shft[14:0], mosi_s};
              if (bit_cnt != 5'd31)
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (sclk_fall && bit_cnt < 5'd16)
              tx_shft <= {tx_shft[14:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_resp.sv
// Directed bench for a2d_resp with a response scoreboard.
// Model mirrors A2D_RAMP_EN when the bench is built with it.
module tb_a2d_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_chnl = '0;
  logic [11:0] wr_data = '0;
  logic        trans_done;
  logic        frm_err;
  logic [2:0]  cur_chnl;
  logic [7:0]  trans_cnt;

  int vectors = 0;
  int errs = 0;
  int n_done = 0;
  int n_err = 0;

  logic [11:0] m_regs [8];
  logic [2:0]  m_cur;
  logic [7:0]  m_cnt;
  logic [15:0] sb [$];

  a2d_resp #(.SCLK_SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .MISO(miso),
    .wr_en(wr_en), .wr_chnl(wr_chnl), .wr_data(wr_data),
    .trans_done(trans_done), .frm_err(frm_err),
    .cur_chnl(cur_chnl), .trans_cnt(trans_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (trans_done) n_done++;
    if (frm_err) n_err++;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_cur = '0;
    m_cnt = '0;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_chnl = ch; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    m_regs[ch] = d;
  endtask

  // One frame of nbits SCLK cycles; optional write during bit wr_at.
  task automatic frame(input string tag, input logic [2:0] ch,
                       input int nbits, input int wr_at,
                       input logic [2:0] wch, input logic [11:0] wd);
    logic [15:0] cmd;
    logic [15:0] rx;
    logic [15:0] exp;
    int d0;
    int e0;
    cmd = {2'b00, ch, 11'h000};
    rx = '0;
    d0 = n_done;
    e0 = n_err;
    if (nbits == 16) sb.push_back({4'b0000, m_regs[m_cur]});
    @(negedge clk);
    ss_n = 1'b0;
    mosi = cmd[15];
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = {rx[14:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      if (i == wr_at) begin
        wr_en = 1'b1; wr_chnl = wch; wr_data = wd;
        @(negedge clk);
        wr_en = 1'b0;
        m_regs[wch] = wd;
      end else begin
        @(negedge clk);
      end
      repeat (3) @(negedge clk);
      sclk = 1'b0;
      if (i < 15) mosi = cmd[14-i];
      repeat (8) @(negedge clk);
    end
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    if (nbits == 16) begin
      exp = sb.pop_front();
      chk({tag, " data"}, rx, exp);
`ifdef A2D_RAMP_EN
      m_regs[m_cur] = m_regs[m_cur] + 12'd1;
`endif
      m_cur = ch;
      m_cnt = m_cnt + 8'd1;
      chk({tag, " done"}, 16'(n_done - d0), 16'd1);
      chk({tag, " err"}, 16'(n_err - e0), 16'd0);
    end else begin
      chk({tag, " done"}, 16'(n_done - d0), 16'd0);
      chk({tag, " err"}, 16'(n_err - e0), 16'd1);
    end
    chk({tag, " chnl"}, {13'd0, cur_chnl}, {13'd0, m_cur});
    chk({tag, " cnt"}, {8'd0, trans_cnt}, {8'd0, m_cnt});
    chk({tag, " miso idle"}, {15'd0, miso}, 16'd0);
  endtask

  initial begin
    int d0;
    int e0;
    m_reset();
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst miso", {15'd0, miso}, 16'd0);
    chk("rst done", {15'd0, trans_done}, 16'd0);
    chk("rst err", {15'd0, frm_err}, 16'd0);
    chk("rst chnl", {13'd0, cur_chnl}, 16'd0);
    chk("rst cnt", {8'd0, trans_cnt}, 16'd0);

    frame("f0", 3'd0, 16, -1, 3'd0, 12'h0);

    wr(3'd4, 12'hABC);
    frame("f4", 3'd4, 16, -1, 3'd0, 12'h0);
    frame("f4b", 3'd0, 16, -1, 3'd0, 12'h0);

    frame("abort", 3'd3, 9, -1, 3'd0, 12'h0);
    frame("post", 3'd5, 16, -1, 3'd0, 12'h0);

    wr(3'd5, 12'h123);
    frame("midwr", 3'd5, 16, 6, 3'd5, 12'h456);
    frame("after", 3'd5, 16, -1, 3'd0, 12'h0);

    d0 = n_done;
    e0 = n_err;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ss_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (8) @(negedge clk);
    chk("mid rst done", 16'(n_done - d0), 16'd0);
    chk("mid rst err", 16'(n_err - e0), 16'd0);
    chk("mid rst cnt", {8'd0, trans_cnt}, 16'd0);
    frame("postrst", 3'd1, 16, -1, 3'd0, 12'h0);

    wr(3'd2, 12'hFFF);
    frame("ramp1", 3'd2, 16, -1, 3'd0, 12'h0);
    frame("ramp2", 3'd2, 16, -1, 3'd0, 12'h0);
    frame("ramp3", 3'd2, 16, -1, 3'd0, 12'h0);

    chk("sb empty", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
